dram_req_queue_mc: RTL and testbench

Parametrised successor to the scratchpad backend's DRAM request queue. Sits between the scratchpad backend scheduler/SRAM read path and the DRAM controller and buffers up to DEPTH DRAM read/write sub-requests in order. Each sub-request carries burst bookkeeping (`sub_id` plus a sub-request count), and the block signals burst completion once the DRAM controller has accepted the last sub-request of a burst. It also adds an almost-full threshold, an occupancy count and sub-id sequence checking.

---
 rtl/dram_req_queue_mc.sv | 145 ++++++++++++++
 tb/tb_dram_req_queue_mc.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_queue_mc.sv
// In-order DRAM sub-request queue between the scratchpad backend and the DRAM controller.
// Tracks burst sub-id sequencing on enqueue and pulses burst completion on the last accept.
module dram_req_queue_mc #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned SUB_W     = 3,
  parameter int unsigned BYTES_W   = 5,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enq_valid,
  input  logic                    enq_write,
  input  logic [ADDR_W-1:0]       enq_addr,
  input  logic [ID_W-1:0]         enq_id,
  input  logic [SUB_W-1:0]        enq_sub_id,
  input  logic [SUB_W-1:0]        enq_num_req_m1,
  input  logic [BYTES_W-1:0]      enq_num_bytes,
  input  logic [DATA_W-1:0]       enq_wdata,
  input  logic                    be_stall,
  input  logic                    dram_be_stall,
  output logic                    enq_ready,
  output logic                    dram_req_valid,
  output logic                    dram_req_write,
  output logic [ID_W-1:0]         dram_req_id,
  output logic [ADDR_W-1:0]       dram_req_addr,
  output logic [BYTES_W-1:0]      dram_req_num_bytes,
  output logic [DATA_W-1:0]       dram_req_wdata,
  output logic                    queue_full,
  output logic                    queue_empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    burst_complete,
  output logic [ID_W-1:0]         burst_id,
  output logic                    sub_id_err,
  output logic                    idle
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [SUB_W-1:0]   r_exp_sub;
  logic               r_in_burst;
  logic               r_sub_id_err;
  logic               r_burst_complete;
  logic [ID_W-1:0]    r_burst_id;

  logic               r_mem_write [DEPTH];
  logic               r_mem_last  [DEPTH];
  logic [ADDR_W-1:0]  r_mem_addr  [DEPTH];
  logic [ID_W-1:0]    r_mem_id    [DEPTH];
  logic [BYTES_W-1:0] r_mem_bytes [DEPTH];
  logic [DATA_W-1:0]  r_mem_wdata [DEPTH];

  logic w_valid;
  logic w_enq;
  logic w_deq;
  logic w_last_in;
  logic w_head_last;

  assign queue_full  = (r_count == CNT_W'(DEPTH));
  assign queue_empty = (r_count == '0);
  assign almost_full = (r_count >= CNT_W'(AF_THRESH));
  assign count       = r_count;
  assign enq_ready   = !queue_full && !be_stall;

  assign w_valid     = !queue_empty;
  assign w_enq       = enq_valid && enq_ready;
  assign w_deq       = w_valid && !dram_be_stall;
  assign w_last_in   = (enq_sub_id == enq_num_req_m1);
  assign w_head_last = w_deq && r_mem_last[r_head];

  // Head fields are masked while empty so the DRAM side never sees stale storage.
  assign dram_req_valid     = w_valid;
  assign dram_req_write     = w_valid & r_mem_write[r_head];
  assign dram_req_id        = {ID_W{w_valid}} & r_mem_id[r_head];
  assign dram_req_addr      = {ADDR_W{w_valid}} & r_mem_addr[r_head];
  assign dram_req_num_bytes = {BYTES_W{w_valid}} & r_mem_bytes[r_head];
  assign dram_req_wdata     = {DATA_W{w_valid}} & r_mem_wdata[r_head];

  assign burst_complete = r_burst_complete;
  assign burst_id       = r_burst_id;
  assign sub_id_err     = r_sub_id_err;
  assign idle           = queue_empty && !r_in_burst;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_exp_sub        <= '0;
      r_in_burst       <= 1'b0;
      r_sub_id_err     <= 1'b0;
      r_burst_complete <= 1'b0;
      r_burst_id       <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_burst_complete <= w_head_last;
      if (w_head_last) begin
        r_burst_id <= r_mem_id[r_head];
      end

      if (w_enq) begin
        if (enq_sub_id != r_exp_sub) begin
          r_sub_id_err <= 1'b1;
        end
        if (w_last_in) begin
          r_exp_sub  <= '0;
          r_in_burst <= 1'b0;
        end else begin
          r_exp_sub  <= enq_sub_id + SUB_W'(1);
          r_in_burst <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem_write[r_tail] <= enq_write;
      r_mem_last[r_tail]  <= w_last_in;
      r_mem_addr[r_tail]  <= enq_addr;
      r_mem_id[r_tail]    <= enq_id;
      r_mem_bytes[r_tail] <= enq_num_bytes;
      r_mem_wdata[r_tail] <= enq_wdata;
    end
  end

endmodule

// File: tb/tb_dram_req_queue_mc.sv
// Directed bench for dram_req_queue_mc: bursts, fill/drain, streaming wrap, sub-id errors,
// stall gating and mid-operation reset, with accepts and completions logged on the falling edge.
module tb_dram_req_queue_mc;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ID_W    = 8;
  localparam int unsigned SUB_W   = 3;
  localparam int unsigned BYTES_W = 5;
  localparam int unsigned DATA_W  = 256;

  logic               CLK = 1'b0;
  logic               RST;
  logic               enq_valid;
  logic               enq_write;
  logic [ADDR_W-1:0]  enq_addr;
  logic [ID_W-1:0]    enq_id;
  logic [SUB_W-1:0]   enq_sub_id;
  logic [SUB_W-1:0]   enq_num_req_m1;
  logic [BYTES_W-1:0] enq_num_bytes;
  logic [DATA_W-1:0]  enq_wdata;
  logic               be_stall;
  logic               dram_be_stall;
  logic               enq_ready;
  logic               dram_req_valid;
  logic               dram_req_write;
  logic [ID_W-1:0]    dram_req_id;
  logic [ADDR_W-1:0]  dram_req_addr;
  logic [BYTES_W-1:0] dram_req_num_bytes;
  logic [DATA_W-1:0]  dram_req_wdata;
  logic               queue_full;
  logic               queue_empty;
  logic               almost_full;
  logic [$clog2(DEPTH):0] count;
  logic               burst_complete;
  logic [ID_W-1:0]    burst_id;
  logic               sub_id_err;
  logic               idle;

  dram_req_queue_mc #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ID_W    (ID_W),
    .SUB_W   (SUB_W),
    .BYTES_W (BYTES_W),
    .DATA_W  (DATA_W)
  ) u_dut (
    .CLK                (CLK),
    .RST                (RST),
    .enq_valid          (enq_valid),
    .enq_write          (enq_write),
    .enq_addr           (enq_addr),
    .enq_id             (enq_id),
    .enq_sub_id         (enq_sub_id),
    .enq_num_req_m1     (enq_num_req_m1),
    .enq_num_bytes      (enq_num_bytes),
    .enq_wdata          (enq_wdata),
    .be_stall           (be_stall),
    .dram_be_stall      (dram_be_stall),
    .enq_ready          (enq_ready),
    .dram_req_valid     (dram_req_valid),
    .dram_req_write     (dram_req_write),
    .dram_req_id        (dram_req_id),
    .dram_req_addr      (dram_req_addr),
    .dram_req_num_bytes (dram_req_num_bytes),
    .dram_req_wdata     (dram_req_wdata),
    .queue_full         (queue_full),
    .queue_empty        (queue_empty),
    .almost_full        (almost_full),
    .count              (count),
    .burst_complete     (burst_complete),
    .burst_id           (burst_id),
    .sub_id_err         (sub_id_err),
    .idle               (idle)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] acc_addr  [$];
  logic [DATA_W-1:0] acc_wdata [$];
  logic [ID_W-1:0]   acc_id    [$];
  logic              acc_write [$];
  int                acc_cyc   [$];
  logic [ID_W-1:0]   bc_id     [$];
  int                bc_cyc    [$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Inputs change just after the rising edge, so falling-edge values are what the next edge sees.
  always @(negedge CLK) begin
    if (!RST) begin
      if (dram_req_valid && !dram_be_stall) begin
        acc_addr.push_back(dram_req_addr);
        acc_wdata.push_back(dram_req_wdata);
        acc_id.push_back(dram_req_id);
        acc_write.push_back(dram_req_write);
        acc_cyc.push_back(cyc);
      end
      if (burst_complete) begin
        bc_id.push_back(burst_id);
        bc_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_mon;
    acc_addr.delete();
    acc_wdata.delete();
    acc_id.delete();
    acc_write.delete();
    acc_cyc.delete();
    bc_id.delete();
    bc_cyc.delete();
  endtask

  function automatic logic [ADDR_W-1:0] a_of(input int i);
    return 32'h1000 + 32'(i) * 32'h20;
  endfunction

  function automatic logic [DATA_W-1:0] wd_of(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic drive(input logic wr, input int idx, input logic [ID_W-1:0] id,
                       input logic [SUB_W-1:0] sub, input logic [SUB_W-1:0] nm1);
    enq_valid      = 1'b1;
    enq_write      = wr;
    enq_addr       = a_of(idx);
    enq_id         = id;
    enq_sub_id     = sub;
    enq_num_req_m1 = nm1;
    enq_num_bytes  = 5'd16;
    enq_wdata      = wd_of(idx);
  endtask

  initial begin
    RST = 1'b1;
    enq_valid = 1'b0;
    enq_write = 1'b0;
    enq_addr = '0;
    enq_id = '0;
    enq_sub_id = '0;
    enq_num_req_m1 = '0;
    enq_num_bytes = '0;
    enq_wdata = '0;
    be_stall = 1'b0;
    dram_be_stall = 1'b0;
    tick();
    tick();
    RST = 1'b0;

    // Reset values
    check("rst_empty", queue_empty, 1);
    check("rst_idle", idle, 1);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_valid", dram_req_valid, 0);
    check("rst_count", count, 0);
    check("rst_full", queue_full, 0);
    check("rst_af", almost_full, 0);
    check("rst_bc", burst_complete, 0);
    check("rst_bid", burst_id, 0);
    check("rst_err", sub_id_err, 0);

    // Single write burst
    clr_mon();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 8'h12, 3'(i), 3'd3);
      tick();
    end
    enq_valid = 1'b0;
    repeat (4) tick();
    check("b1_nacc", acc_addr.size(), 4);
    if (acc_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b1_addr", acc_addr[i], a_of(i));
        check("b1_wdata", acc_wdata[i], wd_of(i));
        check("b1_id", acc_id[i], 8'h12);
        check("b1_write", acc_write[i], 1);
      end
    end
    check("b1_nbc", bc_id.size(), 1);
    if (bc_id.size() == 1 && acc_cyc.size() == 4) begin
      check("b1_bid", bc_id[0], 8'h12);
      check("b1_bc_lat", bc_cyc[0], acc_cyc[3] + 1);
    end
    check("b1_idle", idle, 1);

    // Fill to full with DRAM stalled
    clr_mon();
    dram_be_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 100 + i, 8'h20, 3'(i), 3'd7);
      #1;
      if (i == 8) begin
        check("fill_ready_full", enq_ready, 0);
        check("fill_full", queue_full, 1);
      end
      tick();
      check("fill_count", count, (i < 8) ? i + 1 : 8);
      check("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    // Full + dequeue in the same cycle still refuses the enqueue
    dram_be_stall = 1'b0;
    drive(1'b1, 999, 8'h21, 3'd0, 3'd0);
    tick();
    check("full_no_pass", count, 7);
    enq_valid = 1'b0;
    repeat (9) tick();
    check("drain_nacc", acc_addr.size(), 8);
    if (acc_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) check("drain_addr", acc_addr[i], a_of(100 + i));
    end
    check("drain_nbc", bc_id.size(), 1);
    if (bc_id.size() == 1) check("drain_bid", bc_id[0], 8'h20);
    check("drain_empty", queue_empty, 1);

    // Streaming enqueue/dequeue across the pointer wrap
    clr_mon();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 200 + i, 8'(8'h30 + i / 4), 3'(i % 4), 3'd3);
      tick();
      check("strm_count", count, 1);
    end
    enq_valid = 1'b0;
    repeat (3) tick();
    check("strm_nacc", acc_addr.size(), 20);
    if (acc_addr.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check("strm_addr", acc_addr[i], a_of(200 + i));
        check("strm_wdata", acc_wdata[i], wd_of(200 + i));
      end
    end
    check("strm_nbc", bc_id.size(), 5);
    if (bc_id.size() == 5) begin
      for (int k = 0; k < 5; k++) check("strm_bid", bc_id[k], 8'h30 + k);
      for (int k = 1; k < 5; k++) check("strm_bc_gap", bc_cyc[k] - bc_cyc[k-1], 4);
    end
    check("strm_err", sub_id_err, 0);

    // Out-of-order sub-id
    clr_mon();
    drive(1'b0, 300, 8'h40, 3'd0, 3'd3);
    tick();
    check("ooo_err0", sub_id_err, 0);
    drive(1'b0, 301, 8'h40, 3'd2, 3'd3);
    tick();
    check("ooo_err1", sub_id_err, 1);
    enq_valid = 1'b0;
    repeat (4) tick();
    check("ooo_err_hold", sub_id_err, 1);
    check("ooo_nacc", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("ooo_addr0", acc_addr[0], a_of(300));
      check("ooo_addr1", acc_addr[1], a_of(301));
      check("ooo_write", acc_write[1], 0);
    end
    check("ooo_not_idle", idle, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("ooo_err_rst", sub_id_err, 0);
    check("ooo_idle_rst", idle, 1);

    // be_stall gating, then DRAM stall toggling
    clr_mon();
    be_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 400, 8'h50, 3'd0, 3'd2);
      #1;
      check("bes_ready", enq_ready, 0);
      tick();
      check("bes_count", count, 0);
    end
    be_stall = 1'b0;
    dram_be_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 400 + i, 8'h50, 3'(i), 3'd2);
      tick();
    end
    enq_valid = 1'b0;
    check("dst_count", count, 3);
    for (int k = 0; k < 3; k++) begin
      dram_be_stall = 1'b1;
      tick();
      check("dst_addr", dram_req_addr, a_of(400 + k));
      check("dst_hold_cnt", count, 3 - k);
      tick();
      check("dst_addr_hold", dram_req_addr, a_of(400 + k));
      check("dst_wdata_hold", dram_req_wdata, wd_of(400 + k));
      dram_be_stall = 1'b0;
      tick();
      check("dst_deq_cnt", count, 2 - k);
    end
    tick();
    check("dst_nacc", acc_addr.size(), 3);
    check("dst_nbc", bc_id.size(), 1);
    if (bc_id.size() == 1) check("dst_bid", bc_id[0], 8'h50);

    // Mid-operation reset
    clr_mon();
    dram_be_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 500 + i, (i < 4) ? 8'h60 : 8'h61, (i < 4) ? 3'(i) : 3'd0, 3'd3);
      tick();
    end
    enq_valid = 1'b0;
    check("mr_count5", count, 5);
    check("mr_not_idle", idle, 0);
    dram_be_stall = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mr_count", count, 0);
    check("mr_valid", dram_req_valid, 0);
    check("mr_idle", idle, 1);
    check("mr_bc", burst_complete, 0);
    repeat (3) tick();
    check("mr_nacc", acc_addr.size(), 0);
    check("mr_nbc", bc_id.size(), 0);
    drive(1'b1, 600, 8'h70, 3'd0, 3'd0);
    tick();
    enq_valid = 1'b0;
    check("mr_err", sub_id_err, 0);
    repeat (3) tick();
    check("mr_nacc2", acc_addr.size(), 1);
    check("mr_nbc2", bc_id.size(), 1);
    if (bc_id.size() == 1) check("mr_bid", bc_id[0], 8'h70);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
